free_list: RTL and testbench

- Physical-register allocator for the R10K-style rename stage: a circular FIFO of free physical register tags.
- Dispatch pops one free tag per cycle to rename a destination. The tag goes to the map table's write port and to the ROB as T.
- Retire pushes the superseded tag (T_old) back onto the list.
- On interrupt, all speculatively allocated tags are reclaimed in one cycle, in lockstep with the map table's restore from its architectural map.

---
 rtl/free_list_pkg.sv | 35 +++
 rtl/free_list_if.sv | 22 ++
 rtl/free_list.sv | 72 +++++++
 tb/tb_free_list.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared types and sizing for the rename-stage physical register free list.
// TAG is the tag format exchanged with the map table and ROB.
package free_list_pkg;
    localparam int NUM_PHYS_REG = 64;
    localparam int NUM_ARCH_REG = 32;
    localparam int FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;
    localparam int PHYS_W       = $clog2(NUM_PHYS_REG);
    localparam int FL_PTR_W     = $clog2(FL_SIZE);
    localparam int FL_CNT_W     = FL_PTR_W + 1;

    typedef struct packed {
        logic [PHYS_W-1:0] phys_reg;
        logic              valid;
        logic              ready;
    } TAG;

    typedef struct packed {
        logic alloc_en;
    } ID_FL_PACKET;

    typedef struct packed {
        TAG   alloc_tag;
        logic alloc_valid;
    } FL_ID_PACKET;

    typedef struct packed {
        logic retire_en;
        TAG   retire_t_old;
    } IR_FL_PACKET;

    // Ring pointer increment; keeps wrap correct for non-power-of-two depths.
    function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] p);
        return (p == FL_PTR_W'(FL_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire side bundle of the free list.
// master = rename/retire logic, slave = the free list itself.
interface free_list_if;
    import free_list_pkg::*;

    logic                alloc_en;
    logic                retire_en;
    TAG                  retire_t_old;
    TAG                  alloc_tag;
    logic                alloc_valid;
    logic [FL_CNT_W-1:0] free_count;

    modport master (
        output alloc_en, retire_en, retire_t_old,
        input  alloc_tag, alloc_valid, free_count
    );

    modport slave (
        input  alloc_en, retire_en, retire_t_old,
        output alloc_tag, alloc_valid, free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for R10K-style renaming.
// Interrupt recovery rewinds head to tail, reclaiming all speculative tags.
module free_list
    import free_list_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     interrupt,
    free_list_if.slave fl
);
    localparam logic [FL_CNT_W-1:0] FL_FULL = FL_CNT_W'(FL_SIZE);

    logic [PHYS_W-1:0]   r_list [FL_SIZE];
    logic [FL_PTR_W-1:0] r_head;
    logic [FL_PTR_W-1:0] r_tail;
    logic [FL_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_alloc_fire;
    logic w_retire_fire;
    logic w_unused;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == FL_FULL);
    assign w_alloc_fire  = fl.alloc_en && !w_empty;
    assign w_retire_fire = fl.retire_en && !w_full;
    assign w_unused      = fl.retire_t_old.valid ^ fl.retire_t_old.ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= FL_FULL;
        end else if (interrupt) begin
            r_head  <= r_tail;
            r_count <= FL_FULL;
        end else begin
            if (w_alloc_fire)
                r_head <= ptr_inc(r_head);
            if (w_retire_fire)
                r_tail <= ptr_inc(r_tail);
            r_count <= r_count
                     + FL_CNT_W'(w_retire_fire)
                     - FL_CNT_W'(w_alloc_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++)
                r_list[i] <= PHYS_W'(NUM_ARCH_REG + i);
        end else if (w_retire_fire && !interrupt) begin
            r_list[r_tail] <= fl.retire_t_old.phys_reg;
        end
    end

    // Freed tag is never bypassed: head entry is read from stored state only.
    always_comb begin
        fl.alloc_tag          = '0;
        fl.alloc_tag.phys_reg = r_list[r_head];
        fl.alloc_tag.valid    = 1'b1;
        fl.alloc_tag.ready    = 1'b0;
        fl.alloc_valid        = !w_empty;
        fl.free_count         = r_count;
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset || interrupt)
        !(fl.retire_en && w_full)
    );
endmodule

// File: tb/tb_free_list.sv
// Randomized + directed bench for free_list against a queue-based model.
// Model tracks free, speculative and architectural tag pools.
module tb_free_list;
    import free_list_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic interrupt;

    free_list_if fl();

    free_list u_dut (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .fl        (fl)
    );

    always #5 clock = ~clock;

    int free_q[$];
    int spec_q[$];
    int arch_q[$];
    int nchecks = 0;
    int nerrs   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_use(input int t);
        if (t == 0) return 1'b1;
        foreach (spec_q[k]) if (spec_q[k] == t) return 1'b1;
        foreach (arch_q[k]) if (arch_q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        arch_q.delete();
        for (int i = 0; i < FL_SIZE; i++) free_q.push_back(NUM_ARCH_REG + i);
        for (int i = 1; i < NUM_ARCH_REG; i++) arch_q.push_back(i);
    endtask

    // Reference model: free = queue of tags, spec = allocated-not-retired in order.
    always @(posedge clock) begin
        automatic bit a = fl.alloc_en && (free_q.size() != 0);
        automatic bit r = fl.retire_en && (spec_q.size() != 0);
        automatic int t = 0;
        automatic int old = 0;
        if (reset) begin
            model_reset();
        end else if (interrupt) begin
            for (int i = spec_q.size() - 1; i >= 0; i--)
                free_q.push_front(spec_q[i]);
            spec_q.delete();
        end else begin
            if (a) t = free_q.pop_front();
            if (r) begin
                old = spec_q.pop_front();
                foreach (arch_q[k])
                    if (arch_q[k] == int'(fl.retire_t_old.phys_reg)) begin
                        arch_q.delete(k);
                        break;
                    end
                arch_q.push_back(old);
                free_q.push_back(int'(fl.retire_t_old.phys_reg));
            end
            if (a) spec_q.push_back(t);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("free_count", int'(fl.free_count), free_q.size());
            check("alloc_valid", int'(fl.alloc_valid), int'(free_q.size() != 0));
            check("tag_valid_bit", int'(fl.alloc_tag.valid), 1);
            check("tag_ready_bit", int'(fl.alloc_tag.ready), 0);
            if (free_q.size() != 0) begin
                check("alloc_tag", int'(fl.alloc_tag.phys_reg), free_q[0]);
                check("no_dup", int'(in_use(int'(fl.alloc_tag.phys_reg))), 0);
            end
        end
    end

    task automatic drive(input bit a, input bit r, input int t,
                         input bit i, input bit rs);
        fl.alloc_en     = a;
        fl.retire_en    = r;
        fl.retire_t_old = '{phys_reg: PHYS_W'(t), valid: 1'b1, ready: 1'b0};
        interrupt       = i;
        reset           = rs;
    endtask

    task automatic step(input bit a, input bit r, input int t,
                        input bit i, input bit rs);
        drive(a, r, t, i, rs);
        @(negedge clock);
    endtask

    function automatic int pick_old();
        return arch_q[$urandom_range(0, arch_q.size() - 1)];
    endfunction

    initial begin
        step(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("rst_tag", int'(fl.alloc_tag.phys_reg), 32);
        check("rst_count", int'(fl.free_count), 32);
        check("rst_valid", int'(fl.alloc_valid), 1);

        for (int i = 0; i < 32; i++) begin
            check("seq_tag", int'(fl.alloc_tag.phys_reg), 32 + i);
            step(1, 0, 0, 0, 0);
        end
        check("empty_valid", int'(fl.alloc_valid), 0);
        check("empty_count", int'(fl.free_count), 0);
        step(1, 0, 0, 0, 0);
        check("over_alloc_count", int'(fl.free_count), 0);

        step(0, 1, 5, 0, 0);
        check("ret5_count", int'(fl.free_count), 1);
        check("ret5_tag", int'(fl.alloc_tag.phys_reg), 5);
        step(0, 1, 9, 0, 0);
        check("ret9_count", int'(fl.free_count), 2);
        step(1, 0, 0, 0, 0);
        check("after5_tag", int'(fl.alloc_tag.phys_reg), 9);

        step(0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0);
        check("pre_simul_tag", int'(fl.alloc_tag.phys_reg), 35);
        step(1, 1, 7, 0, 0);
        check("simul_count", int'(fl.free_count), 29);
        check("simul_tag", int'(fl.alloc_tag.phys_reg), 36);
        repeat (28) step(1, 0, 0, 0, 0);
        check("ret7_wrap_tag", int'(fl.alloc_tag.phys_reg), 7);
        check("ret7_wrap_count", int'(fl.free_count), 1);

        step(0, 0, 0, 0, 1);
        repeat (10) step(1, 0, 0, 0, 0);
        check("pre_int_count", int'(fl.free_count), 22);
        step(1, 1, 3, 1, 0);
        check("int_count", int'(fl.free_count), 32);
        check("int_tag", int'(fl.alloc_tag.phys_reg), 32);
        step(1, 0, 0, 0, 0);
        check("int_next_tag", int'(fl.alloc_tag.phys_reg), 33);

        step(0, 0, 0, 0, 1);
        repeat (16) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, pick_old(), 0, 0);
            check("wrap_count", int'(fl.free_count), 16);
        end

        for (int i = 0; i < 20; i++) step(1, 1, pick_old(), 0, 0);
        step(1, 1, pick_old(), 1, 1);
        check("mid_rst_count", int'(fl.free_count), 32);
        check("mid_rst_tag", int'(fl.alloc_tag.phys_reg), 32);

        for (int i = 0; i < 3000; i++) begin
            automatic bit a  = ($urandom % 10) < 7;
            automatic bit r  = (spec_q.size() != 0) && ($urandom % 2 == 1);
            automatic bit it = ($urandom % 50) == 0;
            automatic bit rs = ($urandom % 300) == 0;
            step(a, r, r ? pick_old() : 0, it, rs);
        end

        drive(0, 0, 0, 0, 0);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
